// File: rtl/wr_fifo_pack.sv
// wr_fifo_pack: write-side controller for the synchronous FIFOs.
//   Packs PACK input bytes (lane 0 first, in the least-significant position)
//   into one FIFO word. It then presents that word to the FIFO through a
//   one-entry pending register and a two-state machine (EMPTY/PEND).
// Ports:
//   clk, reset_n      - clock; asynchronous active-low reset
//   din, din_valid    - input byte stream
//   flush             - complete the current partial word (upper lanes zero)
//   full              - FIFO full flag; blocks fifo_wr
//   fifo_wr/fifo_data - write strobe and word (fifo_data is 0 unless PEND)
//   overflow          - sticky; a completed word was dropped while full
//   busy              - a partial word or a pending word exists

// One assembly lane: a byte register that loads or clears.
module wr_fifo_pack_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              ld,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (clr)  q <= '0;
    else if (ld)   q <= din;
  end
endmodule

module wr_fifo_pack #(
  parameter int DATA_W = 8,
  parameter int PACK   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_W-1:0]      din,
  input  logic                   din_valid,
  input  logic                   flush,
  input  logic                   full,
  output logic                   fifo_wr,
  output logic [DATA_W*PACK-1:0] fifo_data,
  output logic                   overflow,
  output logic                   busy
);
  localparam int CW = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic {EMPTY = 1'b0, PEND = 1'b1} state_t;

  state_t                        state;
  logic [CW-1:0]                 byte_cnt;
  logic [PACK-1:0][DATA_W-1:0]   asm_q;
  logic [PACK-1:0][DATA_W-1:0]   merged;
  logic [DATA_W*PACK-1:0]        pend_q;
  logic                          last_byte;
  logic                          complete;

  // A word completes on the last-lane byte, or on a flush with anything
  // buffered (including a byte arriving on the same edge).
  assign last_byte = din_valid && (byte_cnt == CW'(PACK-1));
  assign complete  = last_byte || (flush && (din_valid || (byte_cnt != '0)));

  // Lanes: a same-edge byte is merged into the outgoing word, so the
  // completed word is visible combinationally as 'merged'.
  for (genvar i = 0; i < PACK; i++) begin : g_lane
    logic hit;
    assign hit = din_valid && (byte_cnt == CW'(i));
    assign merged[i] = hit ? din : asm_q[i];

    wr_fifo_pack_lane #(.DATA_W(DATA_W)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (complete),
      .ld      (hit),
      .din     (din),
      .q       (asm_q[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              byte_cnt <= '0;
    else if (complete)         byte_cnt <= '0;
    else if (din_valid)        byte_cnt <= byte_cnt + 1'b1;
  end

  // Pending-word state machine. Output strobe is combinational from the
  // registered state so it drops with reset and reacts to full at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= EMPTY;
      pend_q   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (complete) begin
          pend_q <= merged;
          state  <= PEND;
        end
        PEND: begin
          if (!full) begin
            // Word leaves this edge; a new one may replace it directly.
            if (complete) pend_q <= merged;
            else          state  <= EMPTY;
          end else if (complete) begin
            overflow <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign fifo_wr   = (state == PEND) && !full;
  assign fifo_data = (state == PEND) ? pend_q : '0;
  assign busy      = (byte_cnt != '0) || (state == PEND);

endmodule

// File: tb/tb_wr_fifo_pack.sv
module tb_wr_fifo_pack;
  localparam int DATA_W = 8;
  localparam int PACK   = 4;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [DATA_W-1:0]      din;
  logic                   din_valid;
  logic                   flush;
  logic                   full;
  logic                   fifo_wr;
  logic [DATA_W*PACK-1:0] fifo_data;
  logic                   overflow;
  logic                   busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wr_fifo_pack #(.DATA_W(DATA_W), .PACK(PACK)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .din       (din),
    .din_valid (din_valid),
    .flush     (flush),
    .full      (full),
    .fifo_wr   (fifo_wr),
    .fifo_data (fifo_data),
    .overflow  (overflow),
    .busy      (busy)
  );

  // Advance one edge; inputs change 1ns after it, outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    din = '0; din_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    din = b; din_valid = 1'b1; flush = 1'b0;
    tick();
    idle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; full = 1'b0; idle();
    #12;
    checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL reset_fifo_wr got=%b exp=0", fifo_wr); end
    checks++; if (fifo_data !== 32'h0) begin failures++; $display("FAIL reset_fifo_data got=%h exp=0", fifo_data); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    send(8'h11);
    checks++; if (busy !== 1'b1 || fifo_wr !== 1'b0) begin failures++; $display("FAIL basic_partial busy=%b wr=%b exp busy=1 wr=0", busy, fifo_wr); end
    send(8'h22); send(8'h33); send(8'h44);
    checks++; if (fifo_wr !== 1'b1) begin failures++; $display("FAIL basic_wr got=%b exp=1", fifo_wr); end
    checks++; if (fifo_data !== 32'h44332211) begin failures++; $display("FAIL basic_data got=%h exp=44332211", fifo_data); end
    tick();
    checks++; if (fifo_wr !== 1'b0 || busy !== 1'b0 || fifo_data !== 32'h0) begin failures++; $display("FAIL basic_after wr=%b busy=%b data=%h exp 0/0/0", fifo_wr, busy, fifo_data); end
  endtask

  task automatic test_full_hold();
    full = 1'b1;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    for (int c = 0; c < 5; c++) begin
      checks++; if (fifo_wr !== 1'b0 || fifo_data !== 32'h44332211) begin failures++; $display("FAIL hold_cycle%0d wr=%b data=%h exp wr=0 data=44332211", c, fifo_wr, fifo_data); end
      tick();
    end
    full = 1'b0;
    #1;
    checks++; if (fifo_wr !== 1'b1 || fifo_data !== 32'h44332211) begin failures++; $display("FAIL hold_release wr=%b data=%h exp wr=1 data=44332211", fifo_wr, fifo_data); end
    tick();
    checks++; if (fifo_wr !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL hold_after wr=%b ovf=%b exp 0/0", fifo_wr, overflow); end
  endtask

  task automatic test_flush();
    send(8'hAA); send(8'hBB);
    checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL flush_pre wr=%b exp=0", fifo_wr); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (fifo_wr !== 1'b1 || fifo_data !== 32'h0000BBAA) begin failures++; $display("FAIL flush_word wr=%b data=%h exp wr=1 data=0000bbaa", fifo_wr, fifo_data); end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (fifo_wr !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush_empty wr=%b busy=%b exp 0/0", fifo_wr, busy); end
  endtask

  task automatic test_same_edge();
    din = 8'hCC; din_valid = 1'b1; flush = 1'b1;
    tick();
    idle();
    checks++; if (fifo_wr !== 1'b1 || fifo_data !== 32'h000000CC) begin failures++; $display("FAIL same_edge wr=%b data=%h exp wr=1 data=000000cc", fifo_wr, fifo_data); end
    tick();
    checks++; if (fifo_wr !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL same_edge_after wr=%b busy=%b exp 0/0", fifo_wr, busy); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_word;
    int writes = 0;
    for (int i = 0; i < 16; i++) begin
      din = 8'(i); din_valid = 1'b1;
      tick();
      if ((i % 4) == 3) begin
        exp_word = {8'(i), 8'(i-1), 8'(i-2), 8'(i-3)};
        checks++; if (fifo_wr !== 1'b1 || fifo_data !== exp_word) begin failures++; $display("FAIL stream_word%0d wr=%b data=%h exp wr=1 data=%h", i/4, fifo_wr, fifo_data, exp_word); end
        if (fifo_wr === 1'b1) writes++;
      end else begin
        checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL stream_gap%0d wr=%b exp=0", i, fifo_wr); end
      end
    end
    idle();
    tick();
    checks++; if (writes != 4 || fifo_wr !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL stream_total writes=%0d wr=%b ovf=%b exp 4/0/0", writes, fifo_wr, overflow); end
  endtask

  task automatic test_overflow();
    full = 1'b1;
    for (int i = 1; i <= 8; i++) send(8'(i));
    checks++; if (overflow !== 1'b1 || fifo_data !== 32'h04030201 || fifo_wr !== 1'b0) begin failures++; $display("FAIL ovf_set ovf=%b data=%h wr=%b exp 1/04030201/0", overflow, fifo_data, fifo_wr); end
    full = 1'b0;
    #1;
    checks++; if (fifo_wr !== 1'b1 || fifo_data !== 32'h04030201) begin failures++; $display("FAIL ovf_release wr=%b data=%h exp wr=1 data=04030201", fifo_wr, fifo_data); end
    tick();
    checks++; if (fifo_wr !== 1'b0 || overflow !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ovf_after wr=%b ovf=%b busy=%b exp 0/1/0", fifo_wr, overflow, busy); end
  endtask

  task automatic test_reset_mid();
    full = 1'b1;
    send(8'h51); send(8'h52); send(8'h53); send(8'h54);
    send(8'h61); send(8'h62);
    full = 1'b0;
    #1;
    checks++; if (fifo_wr !== 1'b1 || overflow !== 1'b1) begin failures++; $display("FAIL mid_pre wr=%b ovf=%b exp 1/1", fifo_wr, overflow); end
    reset_n = 1'b0;
    #1;
    checks++; if (fifo_wr !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || fifo_data !== 32'h0) begin failures++; $display("FAIL mid_async wr=%b busy=%b ovf=%b data=%h exp all 0", fifo_wr, busy, overflow, fifo_data); end
    tick();
    reset_n = 1'b1;
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    checks++; if (fifo_wr !== 1'b1 || fifo_data !== 32'hA4A3A2A1) begin failures++; $display("FAIL mid_clean wr=%b data=%h exp wr=1 data=a4a3a2a1", fifo_wr, fifo_data); end
    tick();
    checks++; if (fifo_wr !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_after wr=%b busy=%b exp 0/0", fifo_wr, busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_hold();
    test_flush();
    test_same_edge();
    test_stream();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
